tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter (Send/Din/Sent handshake) among NUM_REQ byte producers.
- Latches the winning requester's byte, runs the full Send/Sent handshake with the transmitter, then returns a four-phase ack to that requester.
- A watchdog flags a transmitter that never asserts Sent.
- Sits between producer logic and a single tx instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 100000, cycles in SEND without tx_sent before timeout. Must exceed one 11-bit frame (~57300 cycles at 5208 cycles/bit).

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester request; hold high with data stable until ack
- req_data  in  8*NUM_REQ  byte of requester i at [8*i+7:8*i]
- ack  out  NUM_REQ  one-hot; ack[i] high while requester i's transfer is acknowledged
- tx_send  out  1  drives transmitter Send
- tx_din  out  8  drives transmitter Din (registered)
- tx_sent  in  1  transmitter Sent
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  index of current/last granted requester
- timeout_err  out  1  sticky watchdog flag
- clr_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (any cycle, including mid-transfer):
  - state=IDLE; ack=0; tx_send=0; tx_din=8'h00; grant_id=0; rr pointer=0; watchdog=0; timeout_err=0.
  - Reset dominates every other input.
- States:
  - IDLE:
    - If any req bit is set: pick the winner by searching upward from ptr, mod NUM_REQ.
    - On that edge: latch tx_din<=req_data[winner], grant_id<=winner, go to SEND.
    - Otherwise stay in IDLE.
  - SEND:
    - tx_send=1 (decoded from state); watchdog increments each cycle.
    - tx_sent=1: go to RELEASE.
    - Watchdog==TIMEOUT_CYCLES and tx_sent=0: set timeout_err, go to RELEASE.
  - RELEASE:
    - tx_send=0.
    - tx_sent=0: go to ACK, clear watchdog; otherwise stay.
    - No timeout in this state.
  - ACK:
    - ack[grant_id]=1, all other ack bits 0.
    - req[grant_id]=0: go to IDLE and set ptr<=(grant_id+1) mod NUM_REQ.
    - ack falls the cycle after req is sampled low.
- Latency:
  - req sampled high at edge N: tx_send high in cycle N+1.
  - tx_sent sampled at edge M: tx_send low in cycle M+1.
  - Minimum one cycle in RELEASE.
- Data: tx_din is stable from entry to SEND until the next grant; later req_data changes are ignored.
- Fairness:
  - ptr advances only on transfer completion (ACK->IDLE).
  - A requester re-asserting immediately waits behind all other pending requesters.
- Boundary conditions:
  - Req dropped before grant: no grant, no ack.
  - Req dropped after grant (protocol violation): transfer still completes; ack pulses for exactly one cycle.
  - Simultaneous req: lowest index at or above ptr wins.
  - tx_sent already high on SEND entry: one SEND cycle, then RELEASE.
  - Timeout: ack is still issued, so the requester never deadlocks.
  - clr_err and a timeout on the same edge: set wins.
- Widths:
  - Watchdog counter width is $clog2(TIMEOUT_CYCLES+1) and saturates.
  - ptr and grant_id arithmetic is mod NUM_REQ.
  - grant_id upper bits are 0 when NUM_REQ<8.
- Outputs: no X on any output after Reset. An illegal state encoding returns to IDLE.

Test Plan:
- Single requester, tx model acking after 20 cycles. req[2]=1, data 8'hA5 → tx_send high the next cycle, tx_din=8'hA5, grant_id=2. After tx_sent falls, ack=4'b0100 until req[2] drops.
- All four req high at reset release, bytes 8'h10..8'h13 → tx_din sequence 10,11,12,13; grant_id 0,1,2,3; exactly one ack bit high at a time.
- req[0] re-asserts immediately after each ack while req[1] is held → grants alternate 0,1,0,1.
- tx_sent held 0 with TIMEOUT_CYCLES=50 → tx_send high exactly 51 cycles, timeout_err=1, ack still issued. clr_err then clears the flag.
- Reset asserted mid-SEND → next cycle: tx_send=0, ack=0, busy=0, ptr=0. A fresh req[3] is then served normally.
- req[1] pulsed for 1 cycle while a transfer to requester 0 is in progress → no grant or ack for requester 1. A req[1] dropped after grant gives a 1-cycle ack pulse.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter (Send/Din/Sent) among NUM_REQ byte producers.
// Latency: req sampled at edge N -> tx_send in cycle N+1; tx_sent at edge M -> tx_send low in M+1.
// Backpressure: requesters hold req/data until ack; the transmitter stalls us via Sent, bounded by a watchdog.
module tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_send,
    output logic [7:0]           tx_din,
    input  logic                 tx_sent,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 timeout_err,
    input  logic                 clr_err
);
    localparam int             WDW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, RELEASE, ACK} state_t;

    state_t               state, state_nxt;
    logic [2:0]           ptr, ptr_nxt;
    logic [WDW-1:0]       wd;
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           sum;
    logic [2:0]           winner;
    logic [7:0]           win_dat;
    logic [NUM_REQ-1:0]   grant_oh;
    logic                 wd_expired;
    logic                 timeout_set;
    logic                 req_held;

    // Rotate requests so bit 0 is the pointer slot; the lowest set bit is the winner.
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) sum = {1'b0, ptr} + 4'(i);
        end
        winner = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : 3'(sum);
        win_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) win_dat = req_data[8*i +: 8];
        end
    end

    always_comb begin
        grant_oh    = NUM_REQ'(1) << grant_id;
        req_held    = |(req & grant_oh);
        wd_expired  = (wd == WD_MAX);
        timeout_set = (state == SEND) && wd_expired && !tx_sent;
        ptr_nxt     = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = SEND;
            SEND:    if (tx_sent || wd_expired) state_nxt = RELEASE;
            RELEASE: if (!tx_sent) state_nxt = ACK;
            ACK:     if (!req_held) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            wd          <= '0;
            tx_din      <= 8'h00;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req) begin
                tx_din   <= win_dat;
                grant_id <= winner;
            end
            // Watchdog saturates at the limit; it is only cleared once Sent has dropped.
            if (state == SEND && !wd_expired) wd <= wd + 1'b1;
            else if (state == RELEASE && !tx_sent) wd <= '0;
            if (timeout_set) timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
            if (state == ACK && !req_held) ptr <= ptr_nxt;
        end
    end

    assign tx_send = (state == SEND);
    assign busy    = (state != IDLE);
    assign ack     = (state == ACK) ? grant_oh : '0;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios plus random producers against a transaction-level model.
module tb_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 50;

    logic        clk;
    logic        Reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_send;
    logic [7:0]  tx_din;
    logic        tx_sent;
    logic        busy;
    logic [2:0]  grant_id;
    logic        timeout_err;
    logic        clr_err;

    tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .Reset(Reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_send(tx_send), .tx_din(tx_din), .tx_sent(tx_sent), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench stopped");
    end

    int n_checks = 0;
    int n_errors = 0;

    // transmitter model: 0 = answers after tx_delay cycles of Send, 1 = never answers
    int tx_mode  = 0;
    int tx_delay = 3;
    int tx_cnt   = 0;
    bit tx_rand  = 0;

    // producer agents
    logic [3:0] drop_mask  = 4'b0;
    logic [3:0] reasm_mask = 4'b0;
    int         reasm_pct  = 0;

    // reference model state
    int         exp_ptr   = 0;
    int         exp_win   = 0;
    logic [7:0] exp_din   = 8'h00;
    logic       prev_send = 1'b0;
    logic [3:0] prev_ack  = 4'b0;
    int         grants[$];
    logic [7:0] dins[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Winner = first pending index at or above the pointer, wrapping mod N.
    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic monitor();
        logic [3:0] oh;
        if (Reset) begin
            exp_ptr   = 0;
            prev_send = 1'b0;
            prev_ack  = 4'b0;
            return;
        end
        if (tx_send && !prev_send) begin
            exp_win = pick(req, exp_ptr);
            chk("grant_id", 32'(grant_id), exp_win);
            if (exp_win >= 0) exp_din = req_data[8*exp_win +: 8];
            chk("tx_din_at_grant", 32'(tx_din), 32'(exp_din));
            grants.push_back(int'(grant_id));
            dins.push_back(tx_din);
        end
        oh = (exp_win >= 0) ? 4'(1 << exp_win) : 4'b0;
        chk("ack_wrong_bit", 32'(ack & ~oh), 0);
        chk("ack_during_send", 32'((ack != 4'b0) && tx_send), 0);
        if (tx_send || ack != 4'b0) chk("busy_active", 32'(busy), 1);
        if (busy) chk("tx_din_hold", 32'(tx_din), 32'(exp_din));
        if (prev_ack != 4'b0 && ack == 4'b0) exp_ptr = (exp_win + 1) % N;
        prev_send = tx_send;
        prev_ack  = ack;
    endtask

    task automatic agents();
        for (int i = 0; i < N; i++) begin
            if (req[i] && ack[i] && drop_mask[i]) begin
                req[i] = 1'b0;
            end else if (!req[i] && !ack[i] && reasm_mask[i] && ($urandom_range(0, 99) < reasm_pct)) begin
                req_data[8*i +: 8] = 8'($urandom);
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tx_mode == 1) begin
            tx_sent = 1'b0;
        end else if (tx_send) begin
            if (tx_cnt >= tx_delay) tx_sent = 1'b1;
            tx_cnt++;
        end else begin
            tx_sent = 1'b0;
            tx_cnt  = 0;
            if (tx_rand) tx_delay = $urandom_range(0, 6);
        end
        monitor();
        agents();
    endtask

    task automatic drain(string tag);
        int k = 0;
        while ((req != 4'b0 || busy) && k < 3000) begin
            cyc();
            k++;
        end
        chk(tag, 32'(k < 3000), 1);
    endtask

    task automatic count_send(output int n);
        n = 0;
        while (tx_send && n < 1000) begin
            n++;
            cyc();
        end
    endtask

    task automatic wait_ack(string tag);
        int k = 0;
        while (ack == 4'b0 && k < 500) begin
            cyc();
            k++;
        end
        chk(tag, 32'(ack != 4'b0), 1);
    endtask

    initial begin
        int n;
        int base;

        // Reset held with every requester asking: reset dominates.
        Reset    = 1'b1;
        req      = 4'hF;
        req_data = 32'h13121110;
        tx_sent  = 1'b0;
        clr_err  = 1'b0;
        cyc();
        cyc();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_send", 32'(tx_send), 0);
        chk("rst_tx_din", 32'(tx_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);

        // All four pending at reset release: served in index order.
        drop_mask = 4'hF;
        Reset = 1'b0;
        drain("drain_all4");
        chk("all4_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("all4_grant", grants[i], i);
            chk("all4_din", 32'(dins[i]), 32'(8'h10 + i));
        end

        // Single requester, transmitter answers after 20 cycles.
        tx_delay  = 20;
        drop_mask = 4'b0;
        req_data[23:16] = 8'hA5;
        req[2] = 1'b1;
        cyc();
        chk("single_tx_send", 32'(tx_send), 1);
        chk("single_tx_din", 32'(tx_din), 32'h A5);
        chk("single_grant", 32'(grant_id), 2);
        req_data[23:16] = 8'h5A;
        count_send(n);
        chk("single_send_cycles", n, 21);
        chk("single_ack_in_release", 32'(ack), 0);
        cyc();
        chk("single_ack_on", 32'(ack), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("single_ack_held", 32'(ack), 32'b0100);
        end
        req[2] = 1'b0;
        cyc();
        chk("single_ack_off", 32'(ack), 0);
        chk("single_idle", 32'(busy), 0);

        // Requester 0 re-asserting right away alternates with waiting requester 1.
        tx_delay   = 2;
        drop_mask  = 4'b0011;
        reasm_mask = 4'b0011;
        reasm_pct  = 100;
        base = grants.size();
        req[0] = 1'b1;
        req[1] = 1'b1;
        n = 0;
        while (grants.size() < base + 4 && n < 500) begin
            cyc();
            n++;
        end
        reasm_mask = 4'b0;
        drain("drain_alt");
        chk("alt_grant0", grants[base], 0);
        chk("alt_grant1", grants[base+1], 1);
        chk("alt_grant2", grants[base+2], 0);
        chk("alt_grant3", grants[base+3], 1);

        // A one-cycle pulse during another transfer is never granted.
        tx_delay  = 5;
        drop_mask = 4'b0001;
        base = grants.size();
        req[0] = 1'b1;
        cyc();
        req[1] = 1'b1;
        cyc();
        req[1] = 1'b0;
        drain("drain_pulse");
        chk("pulse_count", grants.size() - base, 1);
        chk("pulse_grant", grants[base], 0);

        // Requester drops after grant: transfer completes, ack pulses once.
        req[1] = 1'b1;
        cyc();
        chk("drop_grant", 32'(grant_id), 1);
        req[1] = 1'b0;
        wait_ack("drop_ack_seen");
        chk("drop_ack_bit", 32'(ack), 32'b0010);
        n = 0;
        while (ack != 4'b0 && n < 50) begin
            n++;
            cyc();
        end
        chk("drop_ack_len", n, 1);

        // Silent transmitter: watchdog fires after TO+1 Send cycles, ack still issued.
        tx_mode   = 1;
        drop_mask = 4'hF;
        req[1] = 1'b1;
        cyc();
        count_send(n);
        chk("to_send_cycles", n, TO + 1);
        chk("to_flag_set", 32'(timeout_err), 1);
        wait_ack("to_ack_seen");
        chk("to_ack_bit", 32'(ack), 32'b0010);
        cyc();
        cyc();
        chk("to_flag_sticky", 32'(timeout_err), 1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("to_flag_cleared", 32'(timeout_err), 0);

        // Clear held across the timeout edge: set wins.
        clr_err = 1'b1;
        req[1] = 1'b1;
        cyc();
        count_send(n);
        clr_err = 1'b0;
        chk("to2_send_cycles", n, TO + 1);
        chk("to2_set_wins", 32'(timeout_err), 1);
        drain("drain_to2");
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;

        // Reset in the middle of SEND, then simultaneous requests from a zeroed pointer.
        drop_mask = 4'b0;
        req[2] = 1'b1;
        cyc();
        chk("mid_grant", 32'(grant_id), 2);
        cyc();
        cyc();
        cyc();
        Reset  = 1'b1;
        req[2] = 1'b0;
        cyc();
        chk("mid_rst_tx_send", 32'(tx_send), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant", 32'(grant_id), 0);
        chk("mid_rst_din", 32'(tx_din), 0);
        Reset     = 1'b0;
        drop_mask = 4'hF;
        base = grants.size();
        req[1] = 1'b1;
        req[3] = 1'b1;
        cyc();
        chk("post_rst_grant", 32'(grant_id), 1);
        count_send(n);
        chk("post_rst_wd_fresh", n, TO + 1);
        drain("drain_post_rst");
        chk("post_rst_second", grants[base+1], 3);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;

        // Random producers and random transmitter latency against the model.
        tx_mode    = 0;
        tx_rand    = 1;
        reasm_mask = 4'hF;
        reasm_pct  = 30;
        base = grants.size();
        for (int i = 0; i < 1500; i++) cyc();
        reasm_mask = 4'b0;
        drain("drain_random");
        chk("random_progress", 32'(grants.size() - base >= 50), 1);
        chk("random_no_timeout", 32'(timeout_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
